// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_pkg
//  Description : Memory operation codes, LSU state encoding and access-size
//                helper shared by the load/store unit files.
//  Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

    localparam logic [2:0] MEM_LB  = 3'd0;
    localparam logic [2:0] MEM_LH  = 3'd1;
    localparam logic [2:0] MEM_LW  = 3'd2;
    localparam logic [2:0] MEM_LBU = 3'd3;
    localparam logic [2:0] MEM_LHU = 3'd4;
    localparam logic [2:0] MEM_SB  = 3'd5;
    localparam logic [2:0] MEM_SH  = 3'd6;
    localparam logic [2:0] MEM_SW  = 3'd7;
    // Every 3-bit code is an operation; the idle code is a side-effect-free byte read.
    localparam logic [2:0] MEM_NOP = MEM_LB;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_SPLIT  = 2'd2,
        ST_DONE   = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic [2:0] size_bytes;
        logic       misaligned;
        logic       is_store;
        logic       is_signed;
    } align_info_t;

    function automatic logic [2:0] fn_size(input logic [2:0] fn);
        case (fn)
            MEM_LH, MEM_LHU, MEM_SH: fn_size = 3'd2;
            MEM_LW, MEM_SW:          fn_size = 3'd4;
            default:                 fn_size = 3'd1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_align_check.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align_check
//  Description : Decodes an operation code and the low address bits into
//                access size, misalignment, store and sign-extension flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align_check
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  fn_i,
    input  logic [1:0]  addr_lo_i,
    output align_info_t info_o
);

    logic [2:0] w_size;

    always_comb begin
        w_size            = fn_size(fn_i);
        info_o.size_bytes = w_size;
        info_o.is_store   = (fn_i == MEM_SB) || (fn_i == MEM_SH) || (fn_i == MEM_SW);
        info_o.is_signed  = (fn_i == MEM_LB) || (fn_i == MEM_LH);
        case (w_size)
            3'd2:    info_o.misaligned = addr_lo_i[0];
            3'd4:    info_o.misaligned = |addr_lo_i;
            default: info_o.misaligned = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Single-outstanding load/store initiator; misaligned accesses
//                are split into byte operations and reassembled.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_fn,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [2:0]  mem_fn,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic [2:0]  fn_q, fn_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  size_q, size_d;
    logic        store_q, store_d;
    logic        signed_q, signed_d;
    logic        err_q, err_d;
    logic [1:0]  cnt_q, cnt_d;

    align_info_t w_info;
    logic [2:0]  w_last_idx;
    logic        w_last;
    logic [31:0] w_asm;

    lsu_align_check u_align (
        .fn_i      (req_fn),
        .addr_lo_i (req_addr[1:0]),
        .info_o    (w_info)
    );

    assign w_last_idx = size_q - 3'd1;
    assign w_last     = ({1'b0, cnt_q} == w_last_idx);

    // Partial load result with the current byte dropped into its lane.
    always_comb begin
        w_asm = rdata_q;
        w_asm[{cnt_q, 3'b000} +: 8] = mem_rdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            fn_q     <= MEM_NOP;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            size_q   <= 3'd1;
            store_q  <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            fn_q     <= fn_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            size_q   <= size_d;
            store_q  <= store_d;
            signed_q <= signed_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (!w_info.misaligned)    state_d = ST_ACCESS;
                    else if (ALLOW_MISALIGNED) state_d = ST_SPLIT;
                    else                       state_d = ST_DONE;
                end
            end
            ST_ACCESS: state_d = ST_DONE;
            ST_SPLIT:  if (w_last) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fn_d     = fn_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        size_d   = size_q;
        store_d  = store_q;
        signed_d = signed_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    fn_d     = req_fn;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    size_d   = w_info.size_bytes;
                    store_d  = w_info.is_store;
                    signed_d = w_info.is_signed;
                    err_d    = w_info.misaligned && !ALLOW_MISALIGNED;
                    cnt_d    = 2'd0;
                end
            end
            ST_ACCESS: begin
                if (!store_q) rdata_d = mem_rdata;
            end
            ST_SPLIT: begin
                cnt_d = cnt_q + 2'd1;
                if (!store_q) begin
                    rdata_d = w_asm;
                    // Only halves need extension; split words are passed as assembled.
                    if (w_last && size_q == 3'd2)
                        rdata_d = {{16{signed_q & w_asm[15]}}, w_asm[15:0]};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = (state_q == ST_DONE);
        resp_rdata = rdata_q;
        resp_err   = err_q && (state_q == ST_DONE);
        mem_fn     = MEM_NOP;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            ST_ACCESS: begin
                mem_fn    = fn_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            ST_SPLIT: begin
                mem_fn    = store_q ? MEM_SB : MEM_LBU;
                mem_addr  = addr_q + {30'd0, cnt_q};
                mem_wdata = {24'd0, wdata_q[{cnt_q, 3'b000} +: 8]};
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench: byte-array memory, behavioural model of
//                request/response and bus traffic, directed and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam bit MAIN_ALLOW = 1'b1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_fn = MEM_LB;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [2:0]  mem_fn;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        q_valid = 1'b0;
    logic        q_ready;
    logic [2:0]  q_fn = MEM_LB;
    logic [31:0] q_addr = '0;
    logic [31:0] q_wdata = '0;
    logic        q_rv;
    logic [31:0] q_rdata;
    logic        q_err;
    logic [2:0]  q_mfn;
    logic [31:0] q_maddr;
    logic [31:0] q_mwdata;
    logic [31:0] q_mrdata = 32'hCAFE0000;

    always #5 clk = ~clk;

    load_store_unit #(.ALLOW_MISALIGNED(MAIN_ALLOW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_fn(req_fn), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_fn(mem_fn), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(q_valid), .req_ready(q_ready),
        .req_fn(q_fn), .req_addr(q_addr), .req_wdata(q_wdata),
        .resp_valid(q_rv), .resp_rdata(q_rdata), .resp_err(q_err),
        .mem_fn(q_mfn), .mem_addr(q_maddr), .mem_wdata(q_mwdata), .mem_rdata(q_mrdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", what, act, exp, $time);
        end
    endtask

    // Physical memory (written by the DUT's bus) and the model's expected memory.
    logic [7:0] mem    [0:4095];
    logic [7:0] shadow [0:4095];

    function automatic logic [31:0] mem_word(input logic [31:0] a, input int n);
        logic [31:0] v, t;
        v = '0;
        for (int i = 0; i < n; i++) begin
            t = a + 32'(i);
            v[8*i +: 8] = mem[t[11:0]];
        end
        return v;
    endfunction

    function automatic logic [31:0] shadow_word(input logic [31:0] a, input int n);
        logic [31:0] v, t;
        v = '0;
        for (int i = 0; i < n; i++) begin
            t = a + 32'(i);
            v[8*i +: 8] = shadow[t[11:0]];
        end
        return v;
    endfunction

    function automatic logic [31:0] bus_read(input logic [2:0] fn, input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a, 4);
        case (fn)
            MEM_LB:  return {{24{w[7]}}, w[7:0]};
            MEM_LBU: return {24'h0, w[7:0]};
            MEM_LH:  return {{16{w[15]}}, w[15:0]};
            MEM_LHU: return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    // Memory contents are stable between posedges, so a mid-cycle read is equivalent to a combinational one.
    always @(negedge clk) mem_rdata <= bus_read(mem_fn, mem_addr);

    always @(posedge clk) begin
        logic [31:0] t;
        int n;
        n = (mem_fn == MEM_SB) ? 1 : (mem_fn == MEM_SH) ? 2 : (mem_fn == MEM_SW) ? 4 : 0;
        for (int i = 0; i < n; i++) begin
            t = mem_addr + 32'(i);
            mem[t[11:0]] = mem_wdata[8*i +: 8];
        end
    end

    // Behavioural model: one transaction in flight, m_c counts edges since acceptance.
    logic        m_busy = 1'b0;
    int          m_c = 0, m_lat = 0, m_size = 1;
    logic [2:0]  m_fn;
    logic [31:0] m_addr, m_wdata, m_rdata;
    bit          m_store, m_split, m_err;

    always @(posedge clk) begin
        logic [31:0] t, v;
        if (m_busy && !m_err && m_c < m_lat && m_store) begin
            if (m_split) begin
                t = m_addr + 32'(m_c - 1);
                shadow[t[11:0]] = m_wdata[8*(m_c-1) +: 8];
            end else begin
                for (int i = 0; i < m_size; i++) begin
                    t = m_addr + 32'(i);
                    shadow[t[11:0]] = m_wdata[8*i +: 8];
                end
            end
        end
        if (rst) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (m_c == m_lat) m_busy = 1'b0;
            else m_c++;
        end else if (req_valid) begin
            m_fn    = req_fn;
            m_addr  = req_addr;
            m_wdata = req_wdata;
            m_store = (req_fn == MEM_SB) || (req_fn == MEM_SH) || (req_fn == MEM_SW);
            m_size  = (req_fn == MEM_LW || req_fn == MEM_SW) ? 4 :
                      (req_fn == MEM_LH || req_fn == MEM_LHU || req_fn == MEM_SH) ? 2 : 1;
            m_split = (req_addr & 32'(m_size - 1)) != 0;
            m_err   = m_split && !MAIN_ALLOW;
            m_lat   = m_err ? 1 : (m_split ? m_size + 1 : 2);
            v = shadow_word(req_addr, m_size);
            case (req_fn)
                MEM_LB:  v = {{24{v[7]}}, v[7:0]};
                MEM_LH:  v = {{16{v[15]}}, v[15:0]};
                default: ;
            endcase
            m_rdata = m_store ? 32'h0 : v;
            m_busy  = 1'b1;
            m_c     = 1;
        end
    end

    always @(negedge clk) begin
        check_eq("req_ready", {31'h0, req_ready}, {31'h0, !m_busy});
        check_eq("resp_valid", {31'h0, resp_valid}, {31'h0, m_busy && m_c == m_lat});
        if (m_busy && m_c == m_lat) begin
            check_eq("resp_err", {31'h0, resp_err}, {31'h0, m_err});
            if (!m_err) check_eq("resp_rdata", resp_rdata, m_rdata);
            check_eq("memory image", mem_word(m_addr, 4), shadow_word(m_addr, 4));
        end
        if (m_busy && !m_err && m_c < m_lat) begin
            if (m_split) begin
                check_eq("split mem_fn", {29'h0, mem_fn}, {29'h0, m_store ? MEM_SB : MEM_LBU});
                check_eq("split mem_addr", mem_addr, m_addr + 32'(m_c - 1));
                if (m_store)
                    check_eq("split mem_wdata", {24'h0, mem_wdata[7:0]}, {24'h0, m_wdata[8*(m_c-1) +: 8]});
            end else begin
                check_eq("access mem_fn", {29'h0, mem_fn}, {29'h0, m_fn});
                check_eq("access mem_addr", mem_addr, m_addr);
                check_eq("access mem_wdata", mem_wdata, m_wdata);
            end
        end else begin
            check_eq("idle mem_fn", {29'h0, mem_fn}, {29'h0, MEM_NOP});
        end
    end

    logic [31:0] last_rdata, first_addr;
    logic        last_err;
    logic [2:0]  first_fn;
    int          last_lat;

    task automatic preset(input logic [31:0] a, input logic [7:0] b);
        mem[a[11:0]]    = b;
        shadow[a[11:0]] = b;
    endtask

    task automatic wait_ready();
        int g;
        g = 0;
        @(negedge clk);
        while (!req_ready && g < 40) begin
            @(negedge clk);
            g++;
        end
        check_eq("ready wait bound", 32'(g < 40), 32'd1);
    endtask

    task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] wd);
        wait_ready();
        req_valid = 1'b1;
        req_fn    = fn;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        // Busy-time request lines carry noise; the unit must ignore them.
        req_fn    = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        last_lat  = 0;
        do begin
            @(negedge clk);
            last_lat++;
            if (last_lat == 1) begin
                first_fn   = mem_fn;
                first_addr = mem_addr;
            end
        end while (!resp_valid && last_lat < 20);
        req_valid  = 1'b0;
        check_eq("response bound", 32'(last_lat < 20), 32'd1);
        last_rdata = resp_rdata;
        last_err   = resp_err;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f;
        logic [31:0] a;
        for (int i = 0; i < 4096; i++) begin
            mem[i]    = 8'($urandom);
            shadow[i] = mem[i];
        end

        // Reset held with a pending request.
        rst = 1'b1;
        req_valid = 1'b1;
        req_fn = MEM_SW;
        req_addr = 32'h10;
        req_wdata = 32'hDEADBEEF;
        repeat (3) begin
            @(negedge clk);
            check_eq("reset req_ready", {31'h0, req_ready}, 32'd1);
            check_eq("reset mem_fn", {29'h0, mem_fn}, {29'h0, MEM_NOP});
            check_eq("reset resp_valid", {31'h0, resp_valid}, 32'd0);
        end
        check_eq("reset mem_addr", mem_addr, 32'h0);
        check_eq("reset mem_wdata", mem_wdata, 32'h0);
        check_eq("reset resp_rdata", resp_rdata, 32'h0);
        check_eq("reset resp_err", {31'h0, resp_err}, 32'd0);
        rst = 1'b0;
        req_valid = 1'b0;

        // Aligned word load.
        preset(32'h100, 8'hBB); preset(32'h101, 8'hAA);
        preset(32'h102, 8'h99); preset(32'h103, 8'h88);
        issue(MEM_LW, 32'h100, 32'h0);
        check_eq("LW latency", 32'(last_lat), 32'd2);
        check_eq("LW access fn", {29'h0, first_fn}, {29'h0, MEM_LW});
        check_eq("LW rdata", last_rdata, 32'h8899AABB);
        check_eq("LW err", {31'h0, last_err}, 32'd0);

        // Misaligned word store then read-back.
        issue(MEM_SW, 32'h201, 32'h11223344);
        check_eq("SW split latency", 32'(last_lat), 32'd5);
        check_eq("SW split first fn", {29'h0, first_fn}, {29'h0, MEM_SB});
        check_eq("SW split first addr", first_addr, 32'h201);
        check_eq("SW split bytes", mem_word(32'h201, 4), 32'h11223344);
        issue(MEM_LW, 32'h201, 32'h0);
        check_eq("LW split rdata", last_rdata, 32'h11223344);

        // Misaligned half loads, signed and unsigned.
        preset(32'h303, 8'h34); preset(32'h304, 8'hF2);
        issue(MEM_LH, 32'h303, 32'h0);
        check_eq("LH split latency", 32'(last_lat), 32'd3);
        check_eq("LH split fn", {29'h0, first_fn}, {29'h0, MEM_LBU});
        check_eq("LH split rdata", last_rdata, 32'hFFFFF234);
        issue(MEM_LHU, 32'h303, 32'h0);
        check_eq("LHU split rdata", last_rdata, 32'h0000F234);

        // Reset while a split store is partway through.
        for (int i = 0; i < 4; i++) preset(32'h401 + 32'(i), 8'hAA);
        wait_ready();
        req_valid = 1'b1;
        req_fn = MEM_SW;
        req_addr = 32'h401;
        req_wdata = 32'h11223344;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("abort byte1 addr", mem_addr, 32'h402);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort partial bytes", mem_word(32'h401, 4), 32'hAAAA3344);
        check_eq("abort idle", {31'h0, req_ready}, 32'd1);
        repeat (2) begin
            @(negedge clk);
            check_eq("abort no response", {31'h0, resp_valid}, 32'd0);
        end

        // Rejecting instance: misaligned half store, then an aligned load.
        @(negedge clk);
        check_eq("rej ready", {31'h0, q_ready}, 32'd1);
        q_valid = 1'b1; q_fn = MEM_SH; q_addr = 32'h11; q_wdata = 32'h5555;
        @(posedge clk);
        #1 q_valid = 1'b0;
        @(negedge clk);
        check_eq("rej resp_valid", {31'h0, q_rv}, 32'd1);
        check_eq("rej resp_err", {31'h0, q_err}, 32'd1);
        check_eq("rej mem_fn", {29'h0, q_mfn}, {29'h0, MEM_NOP});
        check_eq("rej mem_addr", q_maddr, 32'h0);
        check_eq("rej mem_wdata", q_mwdata, 32'h0);
        @(negedge clk);
        check_eq("rej one-cycle pulse", {31'h0, q_rv}, 32'd0);
        check_eq("rej back to idle", {31'h0, q_ready}, 32'd1);
        check_eq("rej mem_fn after", {29'h0, q_mfn}, {29'h0, MEM_NOP});
        q_valid = 1'b1; q_fn = MEM_LW; q_addr = 32'h40;
        @(posedge clk);
        #1 q_valid = 1'b0;
        @(negedge clk);
        check_eq("rej-inst LW fn", {29'h0, q_mfn}, {29'h0, MEM_LW});
        check_eq("rej-inst LW addr", q_maddr, 32'h40);
        check_eq("rej-inst LW early valid", {31'h0, q_rv}, 32'd0);
        @(negedge clk);
        check_eq("rej-inst LW valid", {31'h0, q_rv}, 32'd1);
        check_eq("rej-inst LW err", {31'h0, q_err}, 32'd0);
        check_eq("rej-inst LW rdata", q_rdata, 32'hCAFE0000);

        // Random traffic, including addresses that wrap past 0xFFFFFFFF.
        for (int k = 0; k < 300; k++) begin
            f = 3'($urandom);
            if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
            else a = 32'($urandom_range(0, 4095));
            issue(f, a, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
